// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute pipeline register with write-back bypass and load-use hazard detection
//
// Purpose: captures the regfile read data and decode fields of the ID instruction and presents them
// to EX one cycle later. Operands are bypassed from the same-cycle write-back. Load-use hazards stall
// upstream and insert a one-cycle bubble. flush_i kills the ID instruction and hold_i freezes EX.
//
// Ports:
//   clk_i, rst_i                        clock, asynchronous active-low reset
//   id_valid_i, id_pc_i, id_imm_i       ID instruction valid, PC, immediate
//   id_ctrl_i                           decoded control bundle (bit MEMRD_BIT = load)
//   id_rs1/rs2/rd_addr_i                ID register indices
//   rs1_data_i, rs2_data_i              regfile read data
//   wb_wr_i, wb_rd_addr_i, wb_rd_data_i write-back port (bypass source)
//   flush_i, hold_i                     kill ID instruction / freeze EX registers
//   stall_o                             load-use stall request (combinational)
//   ex_*                                registered EX fields
//   bubble_cnt_o                        saturating count of load-use bubbles
module id_ex_stage #(
  parameter int n         = 32,
  parameter int address   = 5,
  parameter int CTRL_W    = 16,
  parameter int MEMRD_BIT = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_valid_i,
  input  logic [n-1:0]       id_pc_i,
  input  logic [n-1:0]       id_imm_i,
  input  logic [CTRL_W-1:0]  id_ctrl_i,
  input  logic [address-1:0] id_rs1_addr_i,
  input  logic [address-1:0] id_rs2_addr_i,
  input  logic [address-1:0] id_rd_addr_i,
  input  logic [n-1:0]       rs1_data_i,
  input  logic [n-1:0]       rs2_data_i,
  input  logic               wb_wr_i,
  input  logic [address-1:0] wb_rd_addr_i,
  input  logic [n-1:0]       wb_rd_data_i,
  input  logic               flush_i,
  input  logic               hold_i,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic [n-1:0]       ex_pc_o,
  output logic [n-1:0]       ex_imm_o,
  output logic [CTRL_W-1:0]  ex_ctrl_o,
  output logic [n-1:0]       ex_rs1_data_o,
  output logic [n-1:0]       ex_rs2_data_o,
  output logic [address-1:0] ex_rs1_addr_o,
  output logic [address-1:0] ex_rs2_addr_o,
  output logic [address-1:0] ex_rd_addr_o,
  output logic [15:0]        bubble_cnt_o
);

  logic [n-1:0] op1;
  logic [n-1:0] op2;
  logic [15:0]  bubble_cnt_q;
  logic         rd_match;

  // The regfile only commits on the edge, so a same-cycle write is taken from the WB port.
  // x0 always reads zero, even if something tries to write it.
  always_comb begin
    op1 = rs1_data_i;
    if (id_rs1_addr_i == '0)
      op1 = '0;
    else if (wb_wr_i && (wb_rd_addr_i == id_rs1_addr_i))
      op1 = wb_rd_data_i;

    op2 = rs2_data_i;
    if (id_rs2_addr_i == '0)
      op2 = '0;
    else if (wb_wr_i && (wb_rd_addr_i == id_rs2_addr_i))
      op2 = wb_rd_data_i;
  end

  assign rd_match = (ex_rd_addr_o != '0) &&
                    ((ex_rd_addr_o == id_rs1_addr_i) || (ex_rd_addr_o == id_rs2_addr_i));

  // Load data is only available after EX/MEM, so a dependent ID instruction waits one cycle.
  // Flush and hold take precedence, so no stall is requested under either.
  assign stall_o = id_valid_i && ex_valid_o && ex_ctrl_o[MEMRD_BIT] && rd_match &&
                   !flush_i && !hold_i;

  assign bubble_cnt_o = bubble_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_imm_o      <= '0;
      ex_ctrl_o     <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_rd_addr_o  <= '0;
      bubble_cnt_q  <= '0;
    end else if (flush_i || (!hold_i && stall_o)) begin
      // Flush and bubble both leave EX empty. Only a bubble is counted.
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_imm_o      <= '0;
      ex_ctrl_o     <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_rd_addr_o  <= '0;
      if (!flush_i && (bubble_cnt_q != 16'hFFFF))
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end else if (!hold_i) begin
      ex_valid_o    <= id_valid_i;
      ex_pc_o       <= id_pc_i;
      ex_imm_o      <= id_imm_i;
      ex_ctrl_o     <= id_valid_i ? id_ctrl_i : '0;
      ex_rs1_data_o <= op1;
      ex_rs2_data_o <= op2;
      ex_rs1_addr_o <= id_rs1_addr_i;
      ex_rs2_addr_o <= id_rs2_addr_i;
      ex_rd_addr_o  <= id_rd_addr_i;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [31:0] id_pc_i;
  logic [31:0] id_imm_i;
  logic [15:0] id_ctrl_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic [4:0]  id_rd_addr_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        wb_wr_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_rd_data_i;
  logic        flush_i;
  logic        hold_i;
  logic        stall_o;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_imm_o;
  logic [15:0] ex_ctrl_o;
  logic [31:0] ex_rs1_data_o;
  logic [31:0] ex_rs2_data_o;
  logic [4:0]  ex_rs1_addr_o;
  logic [4:0]  ex_rs2_addr_o;
  logic [4:0]  ex_rd_addr_o;
  logic [15:0] bubble_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_imm_i(id_imm_i), .id_ctrl_i(id_ctrl_i), .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .wb_wr_i(wb_wr_i), .wb_rd_addr_i(wb_rd_addr_i),
    .wb_rd_data_i(wb_rd_data_i), .flush_i(flush_i), .hold_i(hold_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o), .ex_ctrl_o(ex_ctrl_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
    .ex_rd_addr_o(ex_rd_addr_o), .bubble_cnt_o(bubble_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [15:0] ctrl,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_valid_i    = v;
    id_pc_i       = pc;
    id_imm_i      = pc + 32'h1000;
    id_ctrl_i     = ctrl;
    id_rs1_addr_i = rs1;
    id_rs2_addr_i = rs2;
    id_rd_addr_i  = rd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid_o}, 32'd0);
    chk({tag, "_pc"}, ex_pc_o, 32'd0);
    chk({tag, "_imm"}, ex_imm_o, 32'd0);
    chk({tag, "_ctrl"}, {16'd0, ex_ctrl_o}, 32'd0);
    chk({tag, "_rs1d"}, ex_rs1_data_o, 32'd0);
    chk({tag, "_rs2d"}, ex_rs2_data_o, 32'd0);
    chk({tag, "_addrs"}, {17'd0, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o}, 32'd0);
    chk({tag, "_bubbles"}, {16'd0, bubble_cnt_o}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b0;
    set_id(1'b0, 32'd0, 16'd0, 5'd0, 5'd0, 5'd0);
    rs1_data_i = '0; rs2_data_i = '0;
    wb_wr_i = 1'b0; wb_rd_addr_i = '0; wb_rd_data_i = '0;
    flush_i = 1'b0; hold_i = 1'b0;
    tick();
    chk_all_zero("reset");
    rst_i = 1'b1;

    // T2: same-cycle write-back to x5 overrides stale regfile data
    set_id(1'b1, 32'h100, 16'h0010, 5'd5, 5'd6, 5'd9);
    rs1_data_i = 32'h11111111; rs2_data_i = 32'h22222222;
    wb_wr_i = 1'b1; wb_rd_addr_i = 5'd5; wb_rd_data_i = 32'hDEADBEEF;
    tick();
    chk("t2_rs1d", ex_rs1_data_o, 32'hDEADBEEF);
    chk("t2_rs2d", ex_rs2_data_o, 32'h22222222);
    chk("t2_valid", {31'd0, ex_valid_o}, 32'd1);
    chk("t2_pc", ex_pc_o, 32'h100);
    chk("t2_imm", ex_imm_o, 32'h1100);
    chk("t2_ctrl", {16'd0, ex_ctrl_o}, 32'h0010);
    chk("t2_addrs", {17'd0, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o},
        {17'd0, 5'd5, 5'd6, 5'd9});

    // T3: x0 reads zero even with a write-back to x0 and garbage on the regfile port
    set_id(1'b1, 32'h104, 16'h0020, 5'd3, 5'd0, 5'd4);
    rs1_data_i = 32'h33333333; rs2_data_i = 32'h00000777;
    wb_wr_i = 1'b1; wb_rd_addr_i = 5'd0; wb_rd_data_i = 32'h5;
    tick();
    chk("t3_rs2d", ex_rs2_data_o, 32'd0);
    chk("t3_rs1d", ex_rs1_data_o, 32'h33333333);

    // Invalid ID instruction: control bundle must not leak through
    set_id(1'b0, 32'h108, 16'hFFFF, 5'd1, 5'd2, 5'd3);
    wb_wr_i = 1'b0;
    tick();
    chk("inv_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("inv_ctrl", {16'd0, ex_ctrl_o}, 32'd0);

    // T4: lw x7 in EX, add x8,x7,x1 in ID
    set_id(1'b1, 32'h10C, 16'h0001, 5'd2, 5'd0, 5'd7);
    tick();
    chk("t4_load_ctrl", {16'd0, ex_ctrl_o}, 32'h0001);
    set_id(1'b1, 32'h110, 16'h0010, 5'd7, 5'd1, 5'd8);
    rs1_data_i = 32'h00000070; rs2_data_i = 32'h00000001;
    #1;
    chk("t4_stall", {31'd0, stall_o}, 32'd1);
    tick();
    chk("t4_bub_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("t4_bub_ctrl", {16'd0, ex_ctrl_o}, 32'd0);
    chk("t4_bub_cnt", {16'd0, bubble_cnt_o}, 32'd1);
    chk("t4_stall_clear", {31'd0, stall_o}, 32'd0);
    // Load result now arrives via write-back and is bypassed into the re-captured add
    wb_wr_i = 1'b1; wb_rd_addr_i = 5'd7; wb_rd_data_i = 32'hCAFE0007;
    tick();
    chk("t4_add_valid", {31'd0, ex_valid_o}, 32'd1);
    chk("t4_add_rd", {27'd0, ex_rd_addr_o}, 32'd8);
    chk("t4_add_rs1d", ex_rs1_data_o, 32'hCAFE0007);
    chk("t4_add_cnt", {16'd0, bubble_cnt_o}, 32'd1);
    wb_wr_i = 1'b0;

    // T5: flush beats load-use
    set_id(1'b1, 32'h114, 16'h0001, 5'd2, 5'd0, 5'd7);
    tick();
    set_id(1'b1, 32'h118, 16'h0010, 5'd1, 5'd7, 5'd8);
    flush_i = 1'b1;
    #1;
    chk("t5_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("t5_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("t5_ctrl", {16'd0, ex_ctrl_o}, 32'd0);
    chk("t5_cnt", {16'd0, bubble_cnt_o}, 32'd1);
    flush_i = 1'b0;

    // T1: asynchronous reset mid-stream, checked before the next edge
    set_id(1'b1, 32'h11C, 16'h0001, 5'd3, 5'd4, 5'd9);
    tick();
    chk("t1_pre_valid", {31'd0, ex_valid_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk_all_zero("t1");
    @(negedge clk_i);
    rst_i = 1'b1;

    // T6: hold freezes EX across changing ID inputs; counter saturates
    set_id(1'b1, 32'h200, 16'h0001, 5'd1, 5'd2, 5'd10);
    rs1_data_i = 32'hA1A1A1A1; rs2_data_i = 32'hB2B2B2B2;
    tick();
    hold_i = 1'b1;
    force dut.bubble_cnt_q = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h300 + 32'(i * 4), 16'h0040, 5'd10, 5'd11, 5'd12);
      rs1_data_i = 32'h5000 + 32'(i);
      #1;
      chk("t6_hold_stall", {31'd0, stall_o}, 32'd0);
      tick();
      if (i == 0) release dut.bubble_cnt_q;
      chk("t6_hold_valid", {31'd0, ex_valid_o}, 32'd1);
      chk("t6_hold_pc", ex_pc_o, 32'h200);
      chk("t6_hold_ctrl", {16'd0, ex_ctrl_o}, 32'h0001);
      chk("t6_hold_rd", {27'd0, ex_rd_addr_o}, 32'd10);
      chk("t6_hold_rs1d", ex_rs1_data_o, 32'hA1A1A1A1);
      chk("t6_hold_cnt", {16'd0, bubble_cnt_o}, 32'hFFFF);
    end
    hold_i = 1'b0;
    #1;
    chk("t6_stall", {31'd0, stall_o}, 32'd1);
    tick();
    chk("t6_sat_cnt", {16'd0, bubble_cnt_o}, 32'hFFFF);
    chk("t6_bub_valid", {31'd0, ex_valid_o}, 32'd0);
    tick();
    chk("t6_cap_pc", ex_pc_o, 32'h308);
    chk("t6_cap_rd", {27'd0, ex_rd_addr_o}, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
